// File: rtl/mvm_host_driver.sv
// Host-side initiator for the mvm core: buffers operand loads and replays them as
// gap-free bursts, then captures the core's results and re-issues them on a handshaked stream.
module mvm_host_driver #(
    parameter int MAT_SCALE    = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int DONE_TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic                    elem_valid,
    output logic                    elem_ready,
    input  logic [INPUT_WIDTH-1:0]  elem_data,
    output logic                    loadMatrix,
    output logic                    loadVector,
    output logic                    start,
    input  logic                    done,
    output logic [INPUT_WIDTH-1:0]  data_in,
    input  logic [OUTPUT_WIDTH-1:0] data_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [OUTPUT_WIDTH-1:0] res_data,
    output logic                    res_last,
    output logic                    err
);

    localparam int NN = MAT_SCALE * MAT_SCALE;
    localparam int CW = $clog2(NN + 1);
    localparam int AW = (NN > 1) ? $clog2(NN) : 1;
    localparam int RW = (MAT_SCALE > 1) ? $clog2(MAT_SCALE) : 1;
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FILL, PULSE, STREAM, WAIT_DONE, CAPTURE, DRAIN} state_t;
    typedef enum logic [1:0] {K_MAT, K_VEC, K_START} kind_t;

    state_t                 state_reg, state_next;
    kind_t                  kind_reg, kind_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [CW-1:0]          len_reg, len_next;
    logic [TW-1:0]          tcnt_reg, tcnt_next;
    logic                   err_reg, err_next;
    logic [INPUT_WIDTH-1:0] data_in_reg, data_in_next;
    logic                   live_reg;

    logic [INPUT_WIDTH-1:0]  buffer [NN];
    logic [OUTPUT_WIDTH-1:0] rbuf [MAT_SCALE];
    logic [NN-1:0]           buf_we;
    logic [MAT_SCALE-1:0]    rbuf_we;

    // live_reg keeps cmd_ready low while reset is held, even though the FSM sits in IDLE
    assign cmd_ready  = (state_reg == IDLE) && live_reg;
    assign elem_ready = (state_reg == FILL);
    assign loadMatrix = (state_reg == PULSE) && (kind_reg == K_MAT);
    assign loadVector = (state_reg == PULSE) && (kind_reg == K_VEC);
    assign start      = (state_reg == PULSE) && (kind_reg == K_START);
    assign data_in    = data_in_reg;
    assign res_valid  = (state_reg == DRAIN);
    assign res_data   = res_valid ? rbuf[cnt_reg[RW-1:0]] : '0;
    assign res_last   = res_valid && (cnt_reg == CW'(MAT_SCALE - 1));
    assign err        = err_reg;

    // cnt_reg doubles as fill, capture and drain index, so write enables decode it directly
    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_buf_we
            assign buf_we[gi] = (state_reg == FILL) && elem_valid && (cnt_reg == CW'(gi));
        end
        for (genvar gi = 0; gi < MAT_SCALE; gi++) begin : g_rbuf_we
            assign rbuf_we[gi] = (state_reg == CAPTURE) && (cnt_reg == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NN; i++) buffer[i] <= '0;
            for (int i = 0; i < MAT_SCALE; i++) rbuf[i] <= '0;
        end else begin
            for (int i = 0; i < NN; i++) if (buf_we[i]) buffer[i] <= elem_data;
            for (int i = 0; i < MAT_SCALE; i++) if (rbuf_we[i]) rbuf[i] <= data_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            kind_reg    <= K_MAT;
            cnt_reg     <= '0;
            len_reg     <= '0;
            tcnt_reg    <= '0;
            err_reg     <= 1'b0;
            data_in_reg <= '0;
            live_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            kind_reg    <= kind_next;
            cnt_reg     <= cnt_next;
            len_reg     <= len_next;
            tcnt_reg    <= tcnt_next;
            err_reg     <= err_next;
            data_in_reg <= data_in_next;
            live_reg    <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        kind_next    = kind_reg;
        cnt_next     = cnt_reg;
        len_next     = len_reg;
        tcnt_next    = tcnt_reg;
        err_next     = err_reg;
        data_in_next = data_in_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        2'd0: begin
                            kind_next  = K_MAT;
                            len_next   = CW'(NN);
                            cnt_next   = '0;
                            state_next = FILL;
                        end
                        2'd1: begin
                            kind_next  = K_VEC;
                            len_next   = CW'(MAT_SCALE);
                            cnt_next   = '0;
                            state_next = FILL;
                        end
                        2'd2: begin
                            kind_next  = K_START;
                            state_next = PULSE;
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            FILL: begin
                if (elem_valid) begin
                    if (cnt_reg == len_reg - 1'b1) begin
                        cnt_next   = '0;
                        state_next = PULSE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            PULSE: begin
                if (kind_reg == K_START) begin
                    tcnt_next  = '0;
                    state_next = WAIT_DONE;
                end else begin
                    // first element is presented in the cycle right after the pulse
                    data_in_next = buffer[0];
                    cnt_next     = CW'(1);
                    state_next   = STREAM;
                end
            end
            STREAM: begin
                if (cnt_reg == len_reg) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    data_in_next = buffer[cnt_reg[AW-1:0]];
                    cnt_next     = cnt_reg + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    cnt_next   = '0;
                    state_next = CAPTURE;
                end else if (tcnt_reg == TW'(DONE_TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            CAPTURE: begin
                if (cnt_reg == CW'(MAT_SCALE - 1)) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (res_ready) begin
                    if (cnt_reg == CW'(MAT_SCALE - 1)) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mvm_host_driver.sv
// Randomized bench for mvm_host_driver: a behavioural core model plus queue-based
// expectations for operand bursts and result streams.
module tb_mvm_host_driver;

    localparam int N   = 4;
    localparam int IW  = 8;
    localparam int OW  = 16;
    localparam int TO  = 15;
    // done comes 7 cycles after start; N capture edges follow; DRAIN is visible next cycle
    localparam int RES_LAT = 7 + N + 1;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          elem_valid;
    logic          elem_ready;
    logic [IW-1:0] elem_data;
    logic          loadMatrix;
    logic          loadVector;
    logic          start;
    logic          done;
    logic [IW-1:0] data_in;
    logic [OW-1:0] data_out;
    logic          res_valid;
    logic          res_ready;
    logic [OW-1:0] res_data;
    logic          res_last;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [IW-1:0] exp_q[$];
    int            core_y [N];
    int            stalls [N];
    bit            core_en = 1'b1;
    int            core_cnt;

    mvm_host_driver #(
        .MAT_SCALE   (N),
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .DONE_TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .elem_valid(elem_valid),
        .elem_ready(elem_ready),
        .elem_data (elem_data),
        .loadMatrix(loadMatrix),
        .loadVector(loadVector),
        .start     (start),
        .done      (done),
        .data_in   (data_in),
        .data_out  (data_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_last  (res_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model core: done 7 cycles after the start cycle, then y[0..N-1] on consecutive cycles
    always @(negedge clk) begin
        if (!reset) begin
            core_cnt = -1;
            done     = 1'b0;
            data_out = '0;
        end else begin
            if (start && core_en) core_cnt = 0;
            else if (core_cnt >= 0 && core_cnt < 8 + N) core_cnt = core_cnt + 1;
            else core_cnt = -1;
            done = (core_cnt == 7);
            if (core_cnt >= 8 && core_cnt < 8 + N) data_out = OW'(core_y[core_cnt - 8]);
            else data_out = OW'($urandom);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input int op, input bit gaps);
        int L;
        L = exp_q.size();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL load_cmd_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op[1:0];
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (gaps && i > 0) begin
                elem_valid = 1'b0;
                elem_data  = IW'($urandom);
                tick();
            end
            n_cmp++;
            if (elem_ready !== 1'b1 || cmd_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_ready[%0d]: elem_ready=%b cmd_ready=%b want 1/0", i, elem_ready, cmd_ready);
            end
            elem_valid = 1'b1;
            elem_data  = exp_q[i];
            tick();
        end
        elem_valid = 1'b0;
        n_cmp++;
        if ({loadMatrix, loadVector, start} !== ((op == 0) ? 3'b100 : 3'b010) || elem_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL load_pulse: pulses=%b elem_ready=%b want %b/0",
                     {loadMatrix, loadVector, start}, elem_ready, (op == 0) ? 3'b100 : 3'b010);
        end
        tick();
        for (int k = 0; k < L; k++) begin
            n_cmp++;
            if (data_in !== exp_q[k] || {loadMatrix, loadVector, start} !== 3'b000 || cmd_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stream[%0d]: data_in=%0d pulses=%b cmd_ready=%b want %0d/000/0",
                         k, $signed(data_in), {loadMatrix, loadVector, start}, cmd_ready, $signed(exp_q[k]));
            end
            tick();
        end
        n_cmp++;
        if (cmd_ready !== 1'b1 || data_in !== exp_q[L-1]) begin
            n_bad++;
            $display("FAIL stream_end: cmd_ready=%b data_in=%0d want 1/%0d", cmd_ready, $signed(data_in), $signed(exp_q[L-1]));
        end
    endtask

    task automatic run_start;
        int n;
        logic [OW-1:0] e;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL start_cmd_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({loadMatrix, loadVector, start} !== 3'b001) begin
            n_bad++;
            $display("FAIL start_pulse: pulses=%b want 001", {loadMatrix, loadVector, start});
        end
        n = 0;
        while (res_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != RES_LAT) begin
            n_bad++;
            $display("FAIL result_latency: got %0d cycles want %0d", n, RES_LAT);
        end
        for (int i = 0; i < N; i++) begin
            e = OW'(core_y[i]);
            for (int s = 0; s < stalls[i]; s++) begin
                res_ready = 1'b0;
                n_cmp++;
                if (res_valid !== 1'b1 || res_data !== e || res_last !== (i == N - 1)) begin
                    n_bad++;
                    $display("FAIL stall_hold[%0d.%0d]: valid=%b data=%0d last=%b want 1/%0d/%b",
                             i, s, res_valid, $signed(res_data), res_last, $signed(e), i == N - 1);
                end
                tick();
            end
            res_ready = 1'b1;
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== e || res_last !== (i == N - 1)) begin
                n_bad++;
                $display("FAIL result[%0d]: valid=%b data=%0d last=%b want 1/%0d/%b",
                         i, res_valid, $signed(res_data), res_last, $signed(e), i == N - 1);
            end
            tick();
            res_ready = 1'b0;
        end
        n_cmp++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_end: res_valid=%b cmd_ready=%b want 0/1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, elem_ready, loadMatrix, loadVector, start, res_valid, res_last, err, data_in, res_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: cmd_ready=%b elem_ready=%b res_valid=%b err=%b data_in=%0d res_data=%0d want all 0",
                     cmd_ready, elem_ready, res_valid, err, data_in, res_data);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || err !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: cmd_ready=%b err=%b res_valid=%b want 1/0/0", cmd_ready, err, res_valid);
        end
    endtask

    task automatic test_load_matrix;
        exp_q.delete();
        for (int i = 0; i < N * N; i++) exp_q.push_back(IW'(i + 1));
        run_load(0, 1'b1);
        $display("load_matrix 1..16 with gaps done");
    endtask

    task automatic test_load_vector;
        exp_q.delete();
        exp_q.push_back(IW'(-3));
        exp_q.push_back(IW'(5));
        exp_q.push_back(IW'(0));
        exp_q.push_back(IW'(127));
        run_load(1, 1'b0);
        $display("load_vector {-3,5,0,127} done");
    endtask

    task automatic test_start;
        core_en = 1'b1;
        core_y  = '{10, -20, 30, -40};
        stalls  = '{0, 5, 0, 2};
        run_start();
        $display("start fixed results with stalls done");
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 3; r++) begin
            exp_q.delete();
            for (int i = 0; i < N; i++) exp_q.push_back(IW'($urandom));
            run_load(1, r[0]);
            exp_q.delete();
            for (int i = 0; i < N * N; i++) exp_q.push_back(IW'($urandom));
            run_load(0, 1'b0);
            for (int i = 0; i < N; i++) begin
                core_y[i] = $signed(OW'($urandom));
                stalls[i] = $urandom_range(0, 3);
            end
            run_start();
            $display("back_to_back round %0d done", r);
        end
    endtask

    task automatic test_reset_midway;
        bit seen;
        exp_q.delete();
        for (int i = 0; i < N * N; i++) exp_q.push_back(IW'($urandom | 1));
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < N * N; i++) begin
            elem_valid = 1'b1;
            elem_data  = exp_q[i];
            tick();
        end
        elem_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, elem_ready, loadMatrix, loadVector, start, res_valid, res_last, err, data_in, res_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_in_stream: data_in=%0d cmd_ready=%b res_valid=%b want all 0", data_in, cmd_ready, res_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        core_en = 1'b1;
        for (int i = 0; i < N; i++) core_y[i] = $signed(OW'($urandom | 1));
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        tick();
        cmd_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, elem_ready, loadMatrix, loadVector, start, res_valid, res_last, err, data_in, res_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_in_capture: res_valid=%b res_data=%0d cmd_ready=%b want all 0", res_valid, res_data, cmd_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (res_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL no_partial_result: res_valid seen=%b want 0", seen);
        end
        for (int i = 0; i < N; i++) begin
            core_y[i] = $signed(OW'($urandom));
            stalls[i] = 0;
        end
        run_start();
        $display("reset mid-stream and mid-capture done");
    endtask

    task automatic test_illegal;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_pre_err: got %b want 0", err);
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (err !== 1'b1 || cmd_ready !== 1'b1 || {loadMatrix, loadVector, start} !== 3'b000) begin
            n_bad++;
            $display("FAIL illegal_op: err=%b cmd_ready=%b pulses=%b want 1/1/000", err, cmd_ready, {loadMatrix, loadVector, start});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_reset_clear: got %b want 0", err);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        $display("illegal op done");
    endtask

    task automatic test_timeout;
        int t;
        core_en   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (start !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_start_pulse: got %b want 1", start);
        end
        t = 0;
        while (err !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        n_cmp++;
        if (t < TO || t > TO + 2) begin
            n_bad++;
            $display("FAIL timeout_cycles: err after %0d cycles want %0d..%0d", t, TO, TO + 2);
        end
        tick();
        n_cmp++;
        if (err !== 1'b1 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_idle: err=%b cmd_ready=%b res_valid=%b want 1/1/0", err, cmd_ready, res_valid);
        end
        $display("done timeout after %0d cycles", t);
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        elem_valid = 1'b0;
        elem_data  = '0;
        res_ready  = 1'b0;
        for (int i = 0; i < N; i++) begin
            core_y[i] = 0;
            stalls[i] = 0;
        end
        test_reset();
        test_load_matrix();
        test_load_vector();
        test_start();
        test_back_to_back();
        test_reset_midway();
        test_illegal();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
